// File: rtl/bnn_pkg.sv
// ============================================================================
// Module      : bnn_pkg
// Description : Shared types and helpers for the binary max-pool stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pool_state_t;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_pool_row.sv
// ============================================================================
// Module      : bnn_pool_row
// Description : Combinational 2x2 OR-pool of two adjacent binary input rows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_pool_row #(
    parameter int IMG_IN_SIZE = 28
) (
    input  logic [IMG_IN_SIZE-1:0]   i_row_top,
    input  logic [IMG_IN_SIZE-1:0]   i_row_bot,
    output logic [IMG_IN_SIZE/2-1:0] o_pooled
);

    localparam int C_OUT_SIZE = IMG_IN_SIZE / 2;

    genvar j;
    generate
        for (j = 0; j < C_OUT_SIZE; j++) begin : g_pool
            assign o_pooled[j] = i_row_top[2*j] | i_row_top[2*j+1]
                               | i_row_bot[2*j] | i_row_bot[2*j+1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bnn_maxpool2d.sv
// ============================================================================
// Module      : bnn_maxpool2d
// Description : Binary 2x2/stride-2 max-pool, one output row per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_maxpool2d
    import bnn_pkg::*;
#(
    parameter  int C            = 8,
    parameter  int IMG_IN_SIZE  = 28,
    localparam int IMG_OUT_SIZE = IMG_IN_SIZE / 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 data_in_ready,
    input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in  [0:C-1],
    output logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out [0:C-1],
    output logic                                 data_out_ready
);

    localparam int CH_W  = cnt_width(C);
    localparam int ROW_W = cnt_width(IMG_OUT_SIZE);

    localparam logic [CH_W-1:0]  C_LAST_CH  = CH_W'(C - 1);
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(IMG_OUT_SIZE - 1);

    localparam logic [1:0] C_ST_IDLE = IDLE;
    localparam logic [1:0] C_ST_RUN  = RUN;
    localparam logic [1:0] C_ST_DONE = DONE;

    generate
        if ((IMG_IN_SIZE < 2) || (IMG_IN_SIZE % 2 != 0)) begin : g_bad_size
            $error("bnn_maxpool2d: IMG_IN_SIZE must be even and >= 2");
        end
    endgenerate

    logic [1:0]                             r_state;
    logic [CH_W-1:0]                        r_ch;
    logic [ROW_W-1:0]                       r_row;
    logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]   r_img_out [0:C-1];
    logic                                   r_data_out_ready;

    logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]     w_ch_map;
    logic [IMG_IN_SIZE-1:0]                 w_row_top;
    logic [IMG_IN_SIZE-1:0]                 w_row_bot;
    logic [IMG_OUT_SIZE-1:0]                w_pooled;

    // Output row r pools input rows 2r and 2r+1 of the current channel.
    always_comb begin
        w_ch_map  = img_in[r_ch];
        w_row_top = w_ch_map[2*IMG_IN_SIZE*int'(r_row) +: IMG_IN_SIZE];
        w_row_bot = w_ch_map[2*IMG_IN_SIZE*int'(r_row) + IMG_IN_SIZE +: IMG_IN_SIZE];
    end

    bnn_pool_row #(
        .IMG_IN_SIZE (IMG_IN_SIZE)
    ) u_pool_row (
        .i_row_top (w_row_top),
        .i_row_bot (w_row_bot),
        .o_pooled  (w_pooled)
    );

    // A low data_in_ready is an abort: it clears everything just like rst.
    always_ff @(posedge clk) begin
        if (rst || !data_in_ready) begin
            r_state          <= C_ST_IDLE;
            r_ch             <= '0;
            r_row            <= '0;
            r_data_out_ready <= 1'b0;
            for (int i = 0; i < C; i++) begin
                r_img_out[i] <= '0;
            end
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    r_state <= C_ST_RUN;
                    r_ch    <= '0;
                    r_row   <= '0;
                end
                C_ST_RUN: begin
                    r_img_out[r_ch][IMG_OUT_SIZE*int'(r_row) +: IMG_OUT_SIZE] <= w_pooled;
                    if (r_row == C_LAST_ROW) begin
                        r_row <= '0;
                        if (r_ch == C_LAST_CH) begin
                            r_state          <= C_ST_DONE;
                            r_data_out_ready <= 1'b1;
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end else begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                C_ST_DONE: begin
                    r_data_out_ready <= 1'b1;
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign img_out        = r_img_out;
    assign data_out_ready = r_data_out_ready;

endmodule

`default_nettype wire

// File: tb/tb_bnn_maxpool2d.sv
// ============================================================================
// Module      : tb_bnn_maxpool2d
// Description : Directed self-checking bench for default and 2ch/4x4 configs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bnn_maxpool2d;

    localparam int CA  = 8;
    localparam int NA  = 28;
    localparam int OA  = NA / 2;
    localparam int CB  = 2;
    localparam int NB  = 4;
    localparam int OB  = NB / 2;

    logic clk;
    logic rst_a, dir_a, rdy_a;
    logic rst_b, dir_b, rdy_b;
    logic [NA*NA-1:0] img_in_a  [0:CA-1];
    logic [OA*OA-1:0] img_out_a [0:CA-1];
    logic [NB*NB-1:0] img_in_b  [0:CB-1];
    logic [OB*OB-1:0] img_out_b [0:CB-1];

    int n_checks;
    int n_fail;
    int n_edges;

    bnn_maxpool2d #(.C(CA), .IMG_IN_SIZE(NA)) u_dut_a (
        .clk            (clk),
        .rst            (rst_a),
        .data_in_ready  (dir_a),
        .img_in         (img_in_a),
        .img_out        (img_out_a),
        .data_out_ready (rdy_a)
    );

    bnn_maxpool2d #(.C(CB), .IMG_IN_SIZE(NB)) u_dut_b (
        .clk            (clk),
        .rst            (rst_b),
        .data_in_ready  (dir_b),
        .img_in         (img_in_b),
        .img_out        (img_out_b),
        .data_out_ready (rdy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_a(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!rdy_a && n < 400);
    endtask

    task automatic count_b(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!rdy_b && n < 50);
    endtask

    function automatic int ones_a();
        int s = 0;
        for (int i = 0; i < CA; i++) s += $countones(img_out_a[i]);
        return s;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_a = 1'b1; dir_a = 1'b1;
        rst_b = 1'b1; dir_b = 1'b0;
        for (int i = 0; i < CA; i++) img_in_a[i] = '0;
        for (int i = 0; i < CB; i++) img_in_b[i] = '0;

        // Reset held with data_in_ready high on the default-size instance.
        step(2);
        check("rst_ready", 64'(rdy_a), 64'd0);
        check("rst_img_zero", 64'(ones_a()), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        count_a(n_edges);
        check("rst_latency", 64'(n_edges), 64'd113);
        check("zero_img", 64'(ones_a()), 64'd0);

        // All-zero input after an abort, full latency again.
        dir_a = 1'b0;
        step(1);
        check("abort_a_ready", 64'(rdy_a), 64'd0);
        dir_a = 1'b1;
        count_a(n_edges);
        check("zero_latency", 64'(n_edges), 64'd113);
        check("zero_img2", 64'(ones_a()), 64'd0);

        // Sparse pixels at the far corner and near corner of two channels.
        dir_a = 1'b0;
        img_in_a[3][783] = 1'b1;
        img_in_a[7][1]   = 1'b1;
        step(1);
        dir_a = 1'b1;
        count_a(n_edges);
        check("corner_latency", 64'(n_edges), 64'd113);
        check("corner_ch3_bit", 64'(img_out_a[3][195]), 64'd1);
        check("corner_ch7_bit", 64'(img_out_a[7][0]), 64'd1);
        check("corner_total", 64'(ones_a()), 64'd2);
        dir_a = 1'b0;

        // Small config: diagonal and single pixel.
        img_in_b[0] = 16'h8421;
        img_in_b[1] = 16'h4000;
        dir_b = 1'b1;
        step(2);
        check("partial_ch0", 64'(img_out_b[0]), 64'h1);
        check("partial_ch1", 64'(img_out_b[1]), 64'h0);
        check("partial_ready", 64'(rdy_b), 64'd0);
        step(3);
        check("diag_ready", 64'(rdy_b), 64'd1);
        check("diag_ch0", 64'(img_out_b[0]), 64'h9);
        check("diag_ch1", 64'(img_out_b[1]), 64'h8);

        // All ones, then hold and confirm stability.
        dir_b = 1'b0;
        img_in_b[0] = 16'hFFFF;
        img_in_b[1] = 16'hFFFF;
        step(1);
        check("drop_ready", 64'(rdy_b), 64'd0);
        dir_b = 1'b1;
        count_b(n_edges);
        check("ones_latency", 64'(n_edges), 64'd5);
        check("ones_ch0", 64'(img_out_b[0]), 64'hF);
        check("ones_ch1", 64'(img_out_b[1]), 64'hF);
        for (int k = 0; k < 10; k++) begin
            step(1);
            check("hold_ready", 64'(rdy_b), 64'd1);
        end
        check("hold_ch0", 64'(img_out_b[0]), 64'hF);
        check("hold_ch1", 64'(img_out_b[1]), 64'hF);

        // Abort mid-run, then restart with full latency.
        dir_b = 1'b0;
        step(1);
        dir_b = 1'b1;
        step(3);
        dir_b = 1'b0;
        step(1);
        check("abort_ch0", 64'(img_out_b[0]), 64'h0);
        check("abort_ch1", 64'(img_out_b[1]), 64'h0);
        check("abort_ready", 64'(rdy_b), 64'd0);
        dir_b = 1'b1;
        count_b(n_edges);
        check("restart_latency", 64'(n_edges), 64'd5);
        check("restart_ch0", 64'(img_out_b[0]), 64'hF);

        // Reset pulse mid-run while data_in_ready stays high.
        dir_b = 1'b0;
        img_in_b[0] = 16'h8421;
        img_in_b[1] = 16'h4000;
        step(1);
        dir_b = 1'b1;
        step(2);
        rst_b = 1'b1;
        step(1);
        check("mrst_ch0", 64'(img_out_b[0]), 64'h0);
        check("mrst_ch1", 64'(img_out_b[1]), 64'h0);
        check("mrst_ready", 64'(rdy_b), 64'd0);
        rst_b = 1'b0;
        count_b(n_edges);
        check("mrst_latency", 64'(n_edges), 64'd5);
        check("mrst_data_ch0", 64'(img_out_b[0]), 64'h9);
        check("mrst_data_ch1", 64'(img_out_b[1]), 64'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
